// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the three interfaces of the ALU sequencer:
//   cmd_*  : command handshake (valid/ready) with op code and operands A/B
//   alu_*  : drive to the external ALU (op, in1, in2) and its results
//            (out, equal, less)
//   rsp_*  : response handshake (valid/ready) with result, flags and error
// Modports:
//   slave  : the sequencer's view (consumes commands, drives ALU, produces
//            responses)
//   master : the environment's view (issues commands, models the ALU,
//            consumes responses)
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_out;
  logic             alu_equal;
  logic             alu_less;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_equal;
  logic             rsp_less;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_op, alu_in1, alu_in2,
    input  alu_out, alu_equal, alu_less,
    output rsp_valid, rsp_data, rsp_equal, rsp_less, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_op, alu_in1, alu_in2,
    output alu_out, alu_equal, alu_less,
    input  rsp_valid, rsp_data, rsp_equal, rsp_less, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Command-side controller for an external 8-bit ALU. Accepts one command at a
// time, drives the ALU, captures its result/flags and returns them over a
// response handshake. Plain ALU codes take a single execute cycle; MUL_OP is
// computed as a fixed-length shift-add loop (WIDTH iterations of ADD + LSL)
// that reuses the same ALU. Unsupported codes are still sent to the ALU and
// flagged with rsp_err.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : alu_sequencer_if.slave (cmd_*, alu_*, rsp_* signal groups)
// All ALU drive and response outputs come straight from flops; cmd_ready is
// decoded from the state register and forced low while reset is asserted.
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int             WIDTH  = 8,
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] MUL_OP = 5'b11000
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  localparam logic [OPW-1:0] OP_LSL = 5'b10000;
  localparam logic [OPW-1:0] OP_LSR = 5'b10001;
  localparam logic [OPW-1:0] OP_AND = 5'b00000;
  localparam logic [OPW-1:0] OP_OR  = 5'b00001;
  localparam logic [OPW-1:0] OP_NOT = 5'b00010;
  localparam logic [OPW-1:0] OP_XOR = 5'b00011;
  localparam logic [OPW-1:0] OP_ADD = 5'b00100;
  localparam logic [OPW-1:0] OP_SUB = 5'b00101;

  localparam int               CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // True for op codes the ALU implements directly.
  function automatic logic op_is_legal(input logic [OPW-1:0] op);
    logic legal;
    case (op)
      OP_LSL, OP_LSR, OP_AND, OP_OR,
      OP_NOT, OP_XOR, OP_ADD, OP_SUB: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t           state_q,     state_d;
  logic [OPW-1:0]   op_q,        op_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] m_q,         m_d;
  logic [WIDTH-1:0] q_q,         q_d;
  logic [CW-1:0]    count_q,     count_d;
  logic             phase_q,     phase_d;      // 0: ADD phase, 1: SHIFT phase
  logic [OPW-1:0]   alu_op_q,    alu_op_d;
  logic [WIDTH-1:0] alu_in1_q,   alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q,   alu_in2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic             rsp_equal_q, rsp_equal_d;
  logic             rsp_less_q,  rsp_less_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             cmd_ready_s;
  logic             accept_s;

  assign cmd_ready_s = (state_q == ST_IDLE) && !reset;
  assign accept_s    = bus.cmd_valid && cmd_ready_s;

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_equal = rsp_equal_q;
  assign bus.rsp_less  = rsp_less_q;
  assign bus.rsp_err   = rsp_err_q;

  // Next-state and next-output logic. The ALU drive registers are loaded with
  // the values the ALU must see in the *next* state, so they default to 0 and
  // only the transitions into EXEC/MUL phases set them.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    m_d         = m_q;
    q_d         = q_q;
    count_d     = count_q;
    phase_d     = phase_q;
    alu_op_d    = '0;
    alu_in1_d   = '0;
    alu_in2_d   = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_equal_d = rsp_equal_q;
    rsp_less_d  = rsp_less_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d = bus.cmd_op;
          if (bus.cmd_op == MUL_OP) begin
            state_d   = ST_MUL;
            acc_d     = '0;
            m_d       = bus.cmd_a;
            q_d       = bus.cmd_b;
            count_d   = '0;
            phase_d   = 1'b0;
            // First ADD phase: acc (0) + (b[0] ? a : 0)
            alu_op_d  = OP_ADD;
            alu_in1_d = '0;
            alu_in2_d = bus.cmd_b[0] ? bus.cmd_a : '0;
          end else begin
            state_d   = ST_EXEC;
            alu_op_d  = bus.cmd_op;
            alu_in1_d = bus.cmd_a;
            alu_in2_d = bus.cmd_b;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        rsp_data_d  = bus.alu_out;
        rsp_equal_d = bus.alu_equal;
        rsp_less_d  = bus.alu_less;
        rsp_err_d   = !op_is_legal(op_q);
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_MUL: begin
        if (!phase_q) begin
          // ADD result becomes the new accumulator; next: shift m left by 1.
          acc_d     = bus.alu_out;
          phase_d   = 1'b1;
          alu_op_d  = OP_LSL;
          alu_in1_d = m_q;
          alu_in2_d = ONE;
        end else begin
          m_d     = bus.alu_out;
          q_d     = q_q >> 1;
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          phase_d = 1'b0;
          if (count_q == LAST_ITER) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = acc_q;
            rsp_equal_d = 1'b0;
            rsp_less_d  = 1'b0;
            rsp_err_d   = 1'b0;
          end else begin
            // Next ADD uses the freshly shifted m and the next multiplier bit
            // (q_q[1] is bit 0 of q after this shift).
            alu_op_d  = OP_ADD;
            alu_in1_d = acc_q;
            alu_in2_d = q_q[1] ? bus.alu_out : '0;
          end
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      m_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      phase_q     <= 1'b0;
      alu_op_q    <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_equal_q <= 1'b0;
      rsp_less_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      q_q         <= q_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      alu_op_q    <= alu_op_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_equal_q <= rsp_equal_d;
      rsp_less_q  <= rsp_less_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer. Models the 8-bit ALU combinationally on
// the interface and checks responses, latency, ALU drive sequencing, response
// hold behaviour and asynchronous reset against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam logic [4:0] OP_LSL = 5'b10000;
  localparam logic [4:0] OP_LSR = 5'b10001;
  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_XOR = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b11000;
  localparam logic [4:0] OP_BAD = 5'b11111;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_sequencer_if #(.WIDTH(8), .OPW(5)) bus ();

  alu_sequencer #(.WIDTH(8), .OPW(5), .MUL_OP(5'b11000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: unknown codes return 0xFF, shifts by 8 or more give 0.
  always_comb begin
    case (bus.alu_op)
      OP_LSL:   bus.alu_out = (bus.alu_in2 >= 8'd8) ? 8'h00 : (bus.alu_in1 << bus.alu_in2[2:0]);
      OP_LSR:   bus.alu_out = (bus.alu_in2 >= 8'd8) ? 8'h00 : (bus.alu_in1 >> bus.alu_in2[2:0]);
      OP_AND:   bus.alu_out = bus.alu_in1 & bus.alu_in2;
      5'b00001: bus.alu_out = bus.alu_in1 | bus.alu_in2;
      5'b00010: bus.alu_out = ~bus.alu_in1;
      OP_XOR:   bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      OP_ADD:   bus.alu_out = bus.alu_in1 + bus.alu_in2;
      OP_SUB:   bus.alu_out = bus.alu_in1 - bus.alu_in2;
      default:  bus.alu_out = 8'hFF;
    endcase
    bus.alu_equal = (bus.alu_in1 == bus.alu_in2);
    bus.alu_less  = (bus.alu_in1 <  bus.alu_in2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; afterwards corrupt the cmd inputs so
  // that any failure to latch operands shows up in the result.
  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 5'b00001;
    bus.cmd_a     = ~a;
    bus.cmd_b     = ~b;
  endtask

  // Release the response and confirm return to IDLE.
  task automatic drain(input string tag);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // Single-cycle ALU command: EXEC drive, latency 1, captured result/flags.
  task automatic alu_txn(input string tag, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_data,
                         input logic exp_eq, input logic exp_lt, input logic exp_err);
    issue(op, a, b);
    check({tag, "_exec_op"},     32'(bus.alu_op),    32'(op));
    check({tag, "_exec_in1"},    32'(bus.alu_in1),   32'(a));
    check({tag, "_exec_in2"},    32'(bus.alu_in2),   32'(b));
    check({tag, "_exec_noresp"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_exec_ready"},  32'(bus.cmd_ready), 32'd0);
    step();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rsp_data),  32'(exp_data));
    check({tag, "_equal"}, 32'(bus.rsp_equal), 32'(exp_eq));
    check({tag, "_less"},  32'(bus.rsp_less),  32'(exp_lt));
    check({tag, "_err"},   32'(bus.rsp_err),   32'(exp_err));
  endtask

  // Multiply: alternating ADD/LSL drive for 16 cycles, response after edge N+16.
  task automatic mul_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_data);
    issue(OP_MUL, a, b);
    for (int c = 0; c < 16; c++) begin
      check({tag, "_phase_op"}, 32'(bus.alu_op), (c % 2 == 0) ? 32'(OP_ADD) : 32'(OP_LSL));
      check({tag, "_early"},    32'(bus.rsp_valid), 32'd0);
      step();
    end
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rsp_data),  32'(exp_data));
    check({tag, "_equal"}, 32'(bus.rsp_equal), 32'd0);
    check({tag, "_less"},  32'(bus.rsp_less),  32'd0);
    check({tag, "_err"},   32'(bus.rsp_err),   32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 5'b00000;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.rsp_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_alu_op",    32'(bus.alu_op),    32'd0);
    check("rst_alu_in1",   32'(bus.alu_in1),   32'd0);
    check("rst_alu_in2",   32'(bus.alu_in2),   32'd0);
    reset = 1'b0;
    #1;
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();

    // Single-cycle operations
    alu_txn("add", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0);
    drain("add");
    alu_txn("sub", OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0);
    drain("sub");
    alu_txn("xor", OP_XOR, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
    drain("xor");
    alu_txn("lsr", OP_LSR, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0);
    drain("lsr");
    alu_txn("lsl8", OP_LSL, 8'h01, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0);
    drain("lsl8");
    alu_txn("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    drain("and");
    alu_txn("bad", OP_BAD, 8'h12, 8'h34, 8'hFF, 1'b0, 1'b1, 1'b1);
    drain("bad");

    // Multiply
    mul_txn("mul_d_b", 8'h0D, 8'h0B, 8'h8F);
    drain("mul_d_b");
    mul_txn("mul_wrap", 8'h10, 8'h10, 8'h00);
    drain("mul_wrap");
    mul_txn("mul_zero", 8'hFF, 8'h00, 8'h00);
    drain("mul_zero");
    mul_txn("mul_ff", 8'hFF, 8'hFF, 8'h01);
    drain("mul_ff");

    // Response held under back-pressure; a command during RESP is ignored
    alu_txn("hold", OP_ADD, 8'h21, 8'h12, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.cmd_valid = (c == 2);
      bus.cmd_op    = OP_SUB;
      bus.cmd_a     = 8'h55;
      bus.cmd_b     = 8'h11;
      step();
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_data",  32'(bus.rsp_data),  32'h33);
      check("hold_ready", 32'(bus.cmd_ready), 32'd0);
      check("hold_alu_op", 32'(bus.alu_op),   32'd0);
    end
    bus.cmd_valid = 1'b0;
    drain("hold");
    step();
    check("hold_no_accept_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold_no_accept_op",    32'(bus.alu_op),    32'd0);
    check("hold_no_accept_ready", 32'(bus.cmd_ready), 32'd1);

    // Asynchronous reset during a multiply
    issue(OP_MUL, 8'h0D, 8'h0B);
    for (int c = 0; c < 6; c++) step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("arst_alu_op",    32'(bus.alu_op),    32'd0);
    check("arst_alu_in1",   32'(bus.alu_in1),   32'd0);
    check("arst_alu_in2",   32'(bus.alu_in2),   32'd0);
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("arst_no_resp", 32'(bus.rsp_valid), 32'd0);
    end
    alu_txn("post_rst_add", OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0);
    drain("post_rst_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
